// File: rtl/input_cond_pkg.sv
// Shared definitions for the input conditioning stage.
// Contents:
//   rpt_state_e      - per-button auto-repeat FSM state encoding
//   DEF_*            - default timing constants for a 100 MHz board clock
//   max_int()        - helper used to size the repeat counter
package input_cond_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    localparam int DEF_NBTN        = 5;
    localparam int DEF_NSW         = 16;
    localparam int DEF_TICK_DIV    = 100000;
    localparam int DEF_STABLE_CNT  = 20;
    localparam int DEF_REPEAT_DLY  = 500;
    localparam int DEF_REPEAT_RATE = 100;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_cond_debounce_cell.sv
// debounce_cell: debounce counter, level register and edge pulses for one
// already-synchronised channel.
// Ports:
//   clk    - board clock
//   reset  - synchronous, active-high reset
//   tick   - shared debounce tick strobe
//   sync   - synchronised raw input
//   level  - debounced level (registered)
//   rise   - one-cycle pulse, first cycle the level reads 1 after a 0->1 flip
//   fall   - one-cycle pulse, first cycle the level reads 0 after a 1->0 flip
module debounce_cell #(
    parameter int STABLE_CNT = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sync,
    output logic level,
    output logic rise,
    output logic fall
);

    // Counter saturates at STABLE_CNT-1 before the level flips, so this width
    // can never wrap.
    localparam int CW = $clog2(STABLE_CNT + 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          level_r;
    logic          rise_r;
    logic          fall_r;
    logic          flip_s;

    // Next-count and flip decision: agreement clears at once, disagreement
    // only advances on a tick, and the final qualifying tick flips the level.
    always_comb begin
        cnt_next_s = cnt_r;
        flip_s     = 1'b0;
        if (sync == level_r) begin
            cnt_next_s = {CW{1'b0}};
        end else if (tick) begin
            if (cnt_r == CW'(STABLE_CNT - 1)) begin
                flip_s     = 1'b1;
                cnt_next_s = {CW{1'b0}};
            end else begin
                cnt_next_s = cnt_r + CW'(1);
            end
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Counter, level and edge pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= {CW{1'b0}};
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            cnt_r   <= cnt_next_s;
            level_r <= level_r ^ flip_s;
            rise_r  <= flip_s & ~level_r;
            fall_r  <= flip_s & level_r;
        end
    end

    assign level = level_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/input_cond.sv
// input_cond: synchronises and debounces raw push-buttons and slide switches
// on the free-running board clock and produces clean levels plus one-cycle
// press/release/change pulses.
// Optional feature macro: INPUT_COND_REPEAT_EN adds a per-button auto-repeat
// FSM that re-issues btn_press while a button stays held.
// Ports:
//   clk          - board clock
//   reset        - synchronous, active-high reset
//   btn_in       - raw asynchronous buttons   [NBTN]
//   sw_in        - raw asynchronous switches  [NSW]
//   btn_level    - debounced button levels
//   btn_press    - one-cycle pulse on debounced 0->1 (and auto-repeat)
//   btn_release  - one-cycle pulse on debounced 1->0
//   sw_level     - debounced switch levels
//   sw_changed   - one-cycle pulse when any sw_level bit changes
//   tick         - one-cycle debounce tick strobe
module input_cond
    import input_cond_pkg::*;
#(
    parameter int NBTN        = DEF_NBTN,
    parameter int NSW         = DEF_NSW,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int STABLE_CNT  = DEF_STABLE_CNT,
    parameter int REPEAT_DLY  = DEF_REPEAT_DLY,
    parameter int REPEAT_RATE = DEF_REPEAT_RATE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NBTN-1:0] btn_in,
    input  logic [NSW-1:0]  sw_in,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_release,
    output logic [NSW-1:0]  sw_level,
    output logic            sw_changed,
    output logic            tick
);

    localparam int PW = $clog2(TICK_DIV);

    logic [NBTN-1:0] btn_meta_r;
    logic [NBTN-1:0] btn_sync_r;
    logic [NSW-1:0]  sw_meta_r;
    logic [NSW-1:0]  sw_sync_r;

    logic [PW-1:0]   presc_r;
    logic [PW-1:0]   presc_next_s;
    logic            tick_r;

    logic [NBTN-1:0] btn_level_s;
    logic [NBTN-1:0] btn_rise_s;
    logic [NBTN-1:0] btn_fall_s;
    logic [NSW-1:0]  sw_level_s;
    logic [NSW-1:0]  sw_rise_s;
    logic [NSW-1:0]  sw_fall_s;

    // Two-stage synchronisers for every raw input bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta_r <= {NBTN{1'b0}};
            btn_sync_r <= {NBTN{1'b0}};
            sw_meta_r  <= {NSW{1'b0}};
            sw_sync_r  <= {NSW{1'b0}};
        end else begin
            btn_meta_r <= btn_in;
            btn_sync_r <= btn_meta_r;
            sw_meta_r  <= sw_in;
            sw_sync_r  <= sw_meta_r;
        end
    end

    // Prescaler next value: count 0..TICK_DIV-1 and wrap.
    always_comb begin
        if (presc_r == PW'(TICK_DIV - 1)) begin
            presc_next_s = {PW{1'b0}};
        end else begin
            presc_next_s = presc_r + PW'(1);
        end
    end

    // Prescaler and tick register; tick is pre-decoded from the next count so
    // it is high exactly in the cycle the count holds TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r <= {PW{1'b0}};
            tick_r  <= 1'b0;
        end else begin
            presc_r <= presc_next_s;
            tick_r  <= (presc_next_s == PW'(TICK_DIV - 1));
        end
    end

    genvar g;
    generate
        for (g = 0; g < NBTN; g++) begin : g_btn
            debounce_cell #(
                .STABLE_CNT (STABLE_CNT)
            ) u_cell (
                .clk   (clk),
                .reset (reset),
                .tick  (tick_r),
                .sync  (btn_sync_r[g]),
                .level (btn_level_s[g]),
                .rise  (btn_rise_s[g]),
                .fall  (btn_fall_s[g])
            );
        end
        for (g = 0; g < NSW; g++) begin : g_sw
            debounce_cell #(
                .STABLE_CNT (STABLE_CNT)
            ) u_cell (
                .clk   (clk),
                .reset (reset),
                .tick  (tick_r),
                .sync  (sw_sync_r[g]),
                .level (sw_level_s[g]),
                .rise  (sw_rise_s[g]),
                .fall  (sw_fall_s[g])
            );
        end
    endgenerate

`ifdef INPUT_COND_REPEAT_EN
    localparam int RPT_MAX = max_int(REPEAT_DLY, REPEAT_RATE);
    localparam int RW      = $clog2(RPT_MAX + 1);

    rpt_state_e      rpt_state_r [NBTN];
    logic [RW-1:0]   rpt_cnt_r   [NBTN];
    logic [NBTN-1:0] rpt_pulse_r;

    // Per-button auto-repeat FSMs: arm on the debounced press, count ticks
    // down, fire and reload on expiry, and drop back to IDLE once the
    // debounced level reads low.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NBTN; i++) begin
                rpt_state_r[i] <= IDLE;
                rpt_cnt_r[i]   <= {RW{1'b0}};
            end
            rpt_pulse_r <= {NBTN{1'b0}};
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                rpt_pulse_r[i] <= 1'b0;
                case (rpt_state_r[i])
                    IDLE: begin
                        if (btn_rise_s[i]) begin
                            rpt_state_r[i] <= HOLD;
                            rpt_cnt_r[i]   <= RW'(REPEAT_DLY);
                        end else begin
                            rpt_state_r[i] <= IDLE;
                        end
                    end
                    HOLD, REPEAT: begin
                        if (!btn_level_s[i]) begin
                            rpt_state_r[i] <= IDLE;
                        end else if (tick_r) begin
                            if (rpt_cnt_r[i] <= RW'(1)) begin
                                rpt_pulse_r[i] <= 1'b1;
                                rpt_state_r[i] <= REPEAT;
                                rpt_cnt_r[i]   <= RW'(REPEAT_RATE);
                            end else begin
                                rpt_cnt_r[i]   <= rpt_cnt_r[i] - RW'(1);
                            end
                        end else begin
                            rpt_cnt_r[i]   <= rpt_cnt_r[i];
                        end
                    end
                    default: begin
                        rpt_state_r[i] <= IDLE;
                        rpt_cnt_r[i]   <= {RW{1'b0}};
                    end
                endcase
            end
        end
    end

    // Masking with the level drops a repeat that expires on the same tick the
    // debounced level falls, since both registers update on that edge.
    assign btn_press = btn_rise_s | (rpt_pulse_r & btn_level_s);
`else
    assign btn_press = btn_rise_s;
`endif

    assign btn_level   = btn_level_s;
    assign btn_release = btn_fall_s;
    assign sw_level    = sw_level_s;
    assign sw_changed  = |(sw_rise_s | sw_fall_s);
    assign tick        = tick_r;

endmodule

// File: tb/tb_input_cond.sv
module tb_input_cond;

    localparam int NBTN = 5;
    localparam int NSW  = 16;
    localparam int TD   = 4;
    localparam int SC   = 3;
    localparam int RD   = 5;
    localparam int RR   = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NBTN-1:0] btn_in;
    logic [NSW-1:0]  sw_in;
    logic [NBTN-1:0] btn_level;
    logic [NBTN-1:0] btn_press;
    logic [NBTN-1:0] btn_release;
    logic [NSW-1:0]  sw_level;
    logic            sw_changed;
    logic            tick;

    always #5 clk = ~clk;

    input_cond #(
        .NBTN        (NBTN),
        .NSW         (NSW),
        .TICK_DIV    (TD),
        .STABLE_CNT  (SC),
        .REPEAT_DLY  (RD),
        .REPEAT_RATE (RR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .sw_in       (sw_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .sw_level    (sw_level),
        .sw_changed  (sw_changed),
        .tick        (tick)
    );

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- behavioural reference ----------------
    // Inputs seen two edges ago, elapsed clocks since reset, and per channel
    // the number of consecutive mismatching ticks.
    logic [NBTN-1:0] b_s1, b_s2;
    logic [NSW-1:0]  s_s1, s_s2;
    int              m_n;
    int              b_cnt [NBTN];
    int              s_cnt [NSW];
`ifdef INPUT_COND_REPEAT_EN
    int              b_held [NBTN];
`endif
    logic [NBTN-1:0] e_btn_level, e_btn_press, e_btn_release;
    logic [NSW-1:0]  e_sw_level;
    logic            e_sw_changed, e_tick;
    bit              model_valid = 1'b0;

    always @(posedge clk) begin
        logic            tk;
        logic [NBTN-1:0] nbl, np, nr;
        logic [NSW-1:0]  nsl;
        if (reset) begin
            b_s1 <= '0; b_s2 <= '0; s_s1 <= '0; s_s2 <= '0;
            m_n  <= 0;
            for (int i = 0; i < NBTN; i++) begin
                b_cnt[i] <= 0;
`ifdef INPUT_COND_REPEAT_EN
                b_held[i] <= 0;
`endif
            end
            for (int i = 0; i < NSW; i++) s_cnt[i] <= 0;
            e_btn_level <= '0; e_btn_press <= '0; e_btn_release <= '0;
            e_sw_level <= '0; e_sw_changed <= 1'b0; e_tick <= 1'b0;
            model_valid <= 1'b1;
        end else begin
            tk  = ((m_n % TD) == TD - 1);
            nbl = e_btn_level;
            np  = '0;
            nr  = '0;
            for (int i = 0; i < NBTN; i++) begin
                if (b_s2[i] != e_btn_level[i]) begin
                    if (tk) begin
                        if (b_cnt[i] + 1 == SC) begin
                            nbl[i] = ~nbl[i];
                            b_cnt[i] <= 0;
                        end else begin
                            b_cnt[i] <= b_cnt[i] + 1;
                        end
                    end
                end else begin
                    b_cnt[i] <= 0;
                end
                if (nbl[i] && !e_btn_level[i]) np[i] = 1'b1;
                if (!nbl[i] && e_btn_level[i]) nr[i] = 1'b1;
`ifdef INPUT_COND_REPEAT_EN
                // ticks counted since qualification; fire at RD, RD+RR, ...
                if (np[i]) b_held[i] <= 0;
                if (e_btn_level[i] && nbl[i] && tk) begin
                    b_held[i] <= b_held[i] + 1;
                    if (b_held[i] + 1 >= RD && ((b_held[i] + 1 - RD) % RR) == 0)
                        np[i] = 1'b1;
                end
`endif
            end
            nsl = e_sw_level;
            for (int i = 0; i < NSW; i++) begin
                if (s_s2[i] != e_sw_level[i]) begin
                    if (tk) begin
                        if (s_cnt[i] + 1 == SC) begin
                            nsl[i] = ~nsl[i];
                            s_cnt[i] <= 0;
                        end else begin
                            s_cnt[i] <= s_cnt[i] + 1;
                        end
                    end
                end else begin
                    s_cnt[i] <= 0;
                end
            end
            e_btn_level   <= nbl;
            e_btn_press   <= np;
            e_btn_release <= nr;
            e_sw_level    <= nsl;
            e_sw_changed  <= (nsl != e_sw_level);
            e_tick        <= (((m_n + 1) % TD) == TD - 1);
            m_n           <= m_n + 1;
            b_s1 <= btn_in; b_s2 <= b_s1;
            s_s1 <= sw_in;  s_s2 <= s_s1;
        end
    end

    // Every-cycle compare against the reference.
    always @(negedge clk) begin
        if (model_valid) begin
            vectors++;
            if (btn_level !== e_btn_level || btn_press !== e_btn_press ||
                btn_release !== e_btn_release || sw_level !== e_sw_level ||
                sw_changed !== e_sw_changed || tick !== e_tick) begin
                miscompares++;
                $display("FAIL cycle t=%0t lvl %h/%h prs %h/%h rel %h/%h sw %h/%h chg %b/%b tick %b/%b (got/exp)",
                         $time, btn_level, e_btn_level, btn_press, e_btn_press,
                         btn_release, e_btn_release, sw_level, e_sw_level,
                         sw_changed, e_sw_changed, tick, e_tick);
            end
        end
    end

    // ---------------- literal checks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int press_c [NBTN];
    int rel_c   [NBTN];
    int chg_c;

    task automatic clear_counts();
        for (int i = 0; i < NBTN; i++) begin
            press_c[i] = 0;
            rel_c[i]   = 0;
        end
        chg_c = 0;
    endtask

    task automatic run_count(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int i = 0; i < NBTN; i++) begin
                if (btn_press[i])   press_c[i]++;
                if (btn_release[i]) rel_c[i]++;
            end
            if (sw_changed) chg_c++;
        end
    endtask

    int  found;
    int  rpt_cnt;
    int  exp_rpt;
    int  idx;

    initial begin
        reset  = 1'b1;
        btn_in = '1;
        sw_in  = '1;
        repeat (4) @(negedge clk);
        check("reset_btn_level", 32'(btn_level), 32'h0);
        check("reset_sw_level",  32'(sw_level),  32'h0);
        check("reset_pulses",    32'({btn_press, btn_release, sw_changed, tick}), 32'h0);

        // Held inputs qualify on edge 12 after release: sync at edge 2,
        // ticks in cycles after edges 3, 7, 11.
        reset = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("held_press",      32'(btn_press),  32'h1F);
        check("held_btn_level",  32'(btn_level),  32'h1F);
        check("held_sw_level",   32'(sw_level),   32'hFFFF);
        check("held_sw_changed", 32'(sw_changed), 32'h1);
        @(negedge clk);
        check("held_press_1cyc", 32'(btn_press),  32'h0);
        check("held_chg_1cyc",   32'(sw_changed), 32'h0);

        btn_in = '0;
        sw_in  = '0;
        run_count(40);
        check("all_released", 32'(btn_level), 32'h0);

        // 6-cycle glitch on btn_in[0]
        clear_counts();
        btn_in[0] = 1'b1;
        run_count(6);
        btn_in[0] = 1'b0;
        run_count(40);
        check("glitch_press", 32'(press_c[0]), 32'd0);
        check("glitch_level", 32'(btn_level[0]), 32'd0);

        // stable press and release of btn_in[2]
        clear_counts();
        btn_in[2] = 1'b1;
        run_count(40);
        check("b2_press_cnt", 32'(press_c[2]), 32'd1);
        clear_counts();
        btn_in[2] = 1'b0;
        run_count(11);
        check("b2_release_early", 32'(rel_c[2]), 32'd0);
        run_count(30);
        check("b2_release_cnt", 32'(rel_c[2]), 32'd1);

        // switch pattern
        clear_counts();
        sw_in = 16'h0101;
        run_count(40);
        check("sw_level_0101", 32'(sw_level), 32'h0101);
        check("sw_changed_cnt", 32'(chg_c), 32'd1);

        // reset in the middle of btn_in[1] debounce
        btn_in[1] = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        check("midrst_not_yet", 32'(btn_level[1]), 32'd0);
        @(negedge clk);
        check("midrst_press", 32'(btn_press[1]), 32'd1);
        btn_in[1] = 1'b0;
        run_count(40);

        // hold btn_in[3] for 20 ticks after qualification
`ifdef INPUT_COND_REPEAT_EN
        exp_rpt = 9;
`else
        exp_rpt = 1;
`endif
        btn_in[3] = 1'b1;
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            @(negedge clk);
            if (btn_press[3]) found = 1;
        end
        check("b3_qualified", 32'(found), 32'd1);
        rpt_cnt = found;
        for (int c = 0; c < 79; c++) begin
            @(negedge clk);
            if (btn_press[3]) rpt_cnt++;
        end
        check("b3_repeat_cnt", 32'(rpt_cnt), 32'(exp_rpt));
        btn_in[3] = 1'b0;
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            @(negedge clk);
            if (btn_release[3]) found = 1;
        end
        check("b3_released", 32'(found), 32'd1);
        clear_counts();
        run_count(60);
        check("b3_no_press_after", 32'(press_c[3]), 32'd0);

        // randomized phase
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 29) == 0) begin
                idx = $urandom_range(0, NBTN - 1);
                btn_in[idx] = ~btn_in[idx];
            end
            if ($urandom_range(0, 59) == 0) begin
                idx = $urandom_range(0, NSW - 1);
                sw_in[idx] = ~sw_in[idx];
            end
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
